// File: rtl/tonomat_param.sv
// tonomat_param -- parametrised vending-machine controller.
// Accepts 1/5/10 coins one per edge, vends one product at PRICE and pays the
// remaining credit back greedily, one 5-unit or 1-unit coin per cycle.
// Optional feature macro: TONOMAT_CANCEL_EN (cancel/refund path from IDLE).
module tonomat_param #(
   parameter int PRICE    = 3,
   parameter int CREDIT_W = 5
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                RON1,
   input  logic                RON5,
   input  logic                RON10,
   input  logic                CANCEL,
   output logic                PRODUS,
   output logic                R1,
   output logic                R5,
   output logic                BUSY,
   output logic [CREDIT_W-1:0] CREDIT
);

   typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;

   localparam logic [CREDIT_W:0]   PRICE_W = (CREDIT_W+1)'(PRICE);
   localparam logic [CREDIT_W-1:0] FIVE    = CREDIT_W'(5);
   localparam logic [CREDIT_W-1:0] ONE     = CREDIT_W'(1);

   state_t              state, state_nx;
   logic [CREDIT_W-1:0] credit, credit_nx;
   logic [CREDIT_W:0]   coin_val;
   logic [CREDIT_W:0]   sum;
   logic [CREDIT_W:0]   after_price;
   logic                cancel_req;

`ifdef TONOMAT_CANCEL_EN
   assign cancel_req = CANCEL;
`else
   // Refund path not built: CANCEL is a dangling port in this configuration.
   logic unused_cancel;
   assign unused_cancel = CANCEL;
   assign cancel_req    = 1'b0;
`endif

   // Coin priority: RON1 over RON5 over RON10; at most one coin per edge.
   always_comb begin
      coin_val = '0;
      if (RON1)       coin_val = (CREDIT_W+1)'(1);
      else if (RON5)  coin_val = (CREDIT_W+1)'(5);
      else if (RON10) coin_val = (CREDIT_W+1)'(10);
   end

   // One extra bit keeps credit+coin from wrapping before the price compare.
   assign sum         = {1'b0, credit} + coin_val;
   assign after_price = sum - PRICE_W;

   // Next-state and next-credit for the IDLE / VEND / CHANGE sequencer.
   always_comb begin
      // NOTE: every variable gets a default first so no path infers a latch.
      state_nx  = state;
      credit_nx = credit;
      case (state)
         IDLE: begin
            if (cancel_req) begin
               credit_nx = sum[CREDIT_W-1:0];
               if (sum != '0) state_nx = CHANGE;
            end else if (sum >= PRICE_W) begin
               credit_nx = after_price[CREDIT_W-1:0];
               state_nx  = VEND;
            end else begin
               credit_nx = sum[CREDIT_W-1:0];
            end
         end
         VEND: begin
            state_nx = (credit != '0) ? CHANGE : IDLE;
         end
         CHANGE: begin
            credit_nx = (credit >= FIVE) ? credit - FIVE : credit - ONE;
            if (credit_nx == '0) state_nx = IDLE;
         end
         default: begin
            state_nx  = IDLE;
            credit_nx = '0;
         end
      endcase
   end

   // State, credit and Moore outputs registered from the next state/credit.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state  <= IDLE;
         credit <= '0;
         PRODUS <= 1'b0;
         R1     <= 1'b0;
         R5     <= 1'b0;
         BUSY   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state  <= state_nx;
         credit <= credit_nx;
         PRODUS <= (state_nx == VEND);
         R5     <= (state_nx == CHANGE) && (credit_nx >= FIVE);
         R1     <= (state_nx == CHANGE) && (credit_nx <  FIVE);
         BUSY   <= (state_nx != IDLE);
      end
   end

   assign CREDIT = credit;

endmodule
